// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT11/DHT22 single-wire reader.
// Optional feature macro: DHT_CHECKSUM_EN (frame checksum verification).
package dht_pkg;

    localparam int unsigned FRAME_BITS = 40;
    localparam int unsigned CNT_W      = 15;
    localparam int unsigned BIT_CNT_W  = 6;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START_LOW = 4'd1,
        WAIT_RESP = 4'd2,
        RESP_LOW  = 4'd3,
        RESP_HIGH = 4'd4,
        BIT_LOW   = 4'd5,
        BIT_HIGH  = 4'd6,
        DONE      = 4'd7,
        ERROR     = 4'd8
    } dht_state_t;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_NO_RESP     = 2'b01;
    localparam logic [1:0] ERR_BIT_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_CHECKSUM    = 2'b11;

    // Low byte of the sum of the four data bytes of a frame.
    function automatic logic [7:0] frame_checksum(input logic [FRAME_BITS-1:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s;
    endfunction

endpackage

// File: rtl/dht_reader_if.sv
// Request/status bundle between the DHT reader and its host / pad.
interface dht_reader_if;
    import dht_pkg::*;

    logic                  start;
    logic                  dht_in;
    logic                  dht_oe;
    logic [FRAME_BITS-1:0] data_out;
    logic                  valid;
    logic                  busy;
    logic                  err;
    logic [1:0]            err_code;

    modport master (
        output start, dht_in,
        input  dht_oe, data_out, valid, busy, err, err_code
    );

    modport slave (
        input  start, dht_in,
        output dht_oe, data_out, valid, busy, err, err_code
    );

endinterface

// File: rtl/dht_us_timer.sv
// Microsecond prescaler plus saturating phase counter, cleared on demand.
module dht_us_timer
    import dht_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] count_us
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign tick     = (presc_q == PRE_LAST);
    assign count_us = count_q;

    // Next prescaler / phase count; phase count holds at full scale.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (clear) begin
            presc_d = '0;
            count_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PRE_W'(1);
            if (tick && (count_q != '1)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dht_reader.sv
// DHT11/DHT22 reader: drives the start pulse, decodes the 40-bit reply and
// presents the last good frame to the SPI slave.
// Optional feature macro: DHT_CHECKSUM_EN (reject frames with a bad checksum).
module dht_reader
    import dht_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned BIT_THRESH_US = 40,
    parameter int unsigned TIMEOUT_US    = 200
) (
    input  logic        clk,
    input  logic        rst,
    dht_reader_if.slave bus
);

    localparam logic [CNT_W-1:0]     START_LAST   = CNT_W'(START_LOW_US - 1);
    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0]     THRESH       = CNT_W'(BIT_THRESH_US);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(FRAME_BITS - 1);

    dht_state_t state_q, state_d;

    logic                  sync1_q, sync2_q, prev_q;
    logic                  rise_c, fall_c;
    logic                  us_tick_c;
    logic [CNT_W-1:0]      phase_us;
    logic                  phase_clear_c;
    logic                  start_done_c, timeout_c, bit_val_c;

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]            err_code_d;

    logic                  oe_q, busy_q, valid_q, err_q;
    logic [1:0]            err_code_q;
    logic [FRAME_BITS-1:0] data_q;

    dht_us_timer #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (phase_clear_c),
        .tick     (us_tick_c),
        .count_us (phase_us)
    );

    // Two-flop synchronizer for the pad input plus previous value for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= bus.dht_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_c        = sync2_q & ~prev_q;
    assign fall_c        = ~sync2_q & prev_q;
    assign start_done_c  = us_tick_c && (phase_us == START_LAST);
    assign timeout_c     = us_tick_c && (phase_us == TIMEOUT_LAST);
    // Phase count lags the true high width by one unit, so >= means "wider than".
    assign bit_val_c     = (phase_us >= THRESH);
    assign phase_clear_c = (state_d != state_q);

    // Protocol sequencing: next state, shift register and failure cause.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = START_LOW;
                    bit_cnt_d = '0;
                end
            end
            START_LOW: begin
                if (start_done_c) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (fall_c) begin
                    state_d = RESP_LOW;
                end else if (timeout_c) begin
                    state_d    = ERROR;
                    err_code_d = ERR_NO_RESP;
                end
            end
            RESP_LOW: begin
                if (rise_c) begin
                    state_d = RESP_HIGH;
                end else if (timeout_c) begin
                    state_d    = ERROR;
                    err_code_d = ERR_NO_RESP;
                end
            end
            RESP_HIGH: begin
                if (fall_c) begin
                    state_d = BIT_LOW;
                end else if (timeout_c) begin
                    state_d    = ERROR;
                    err_code_d = ERR_NO_RESP;
                end
            end
            BIT_LOW: begin
                if (rise_c) begin
                    state_d = BIT_HIGH;
                end else if (timeout_c) begin
                    state_d    = ERROR;
                    err_code_d = ERR_BIT_TIMEOUT;
                end
            end
            BIT_HIGH: begin
                if (fall_c) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], bit_val_c};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef DHT_CHECKSUM_EN
                        if (frame_checksum(shift_d) != shift_d[7:0]) begin
                            state_d    = ERROR;
                            err_code_d = ERR_CHECKSUM;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = BIT_LOW;
                    end
                end else if (timeout_c) begin
                    state_d    = ERROR;
                    err_code_d = ERR_BIT_TIMEOUT;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, shift register and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            oe_q       <= (state_d == START_LOW);
            busy_q     <= (state_d != IDLE) && (state_d != DONE) && (state_d != ERROR);
            valid_q    <= (state_d == DONE);
            err_q      <= (state_d == ERROR);
            err_code_q <= err_code_d;
            if (state_d == DONE) data_q <= shift_d;
        end
    end

    assign bus.dht_oe   = oe_q;
    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
    assign bus.data_out = data_q;

endmodule

// File: tb/tb_dht_reader.sv
// Self-checking bench for dht_reader with a behavioural single-wire sensor.
// Two readers share the bus model: one with the full 18 ms start pulse, one
// with a short start pulse so the randomized/error scenarios stay quick.
module tb_dht_reader;

    localparam int unsigned CLK_HZ        = 1_000_000;
    localparam int unsigned START_US      = 18000;
    localparam int unsigned FAST_START_US = 1000;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic sensor_q = 1'b1;
    logic start_q  = 1'b0;
    logic sel      = 1'b0;

    always #5 clk = ~clk;

    dht_reader_if bm ();
    dht_reader_if bf ();

    assign bm.start  = start_q & ~sel;
    assign bf.start  = start_q & sel;
    assign bm.dht_in = sensor_q & ~bm.dht_oe;
    assign bf.dht_in = sensor_q & ~bf.dht_oe;

    dht_reader #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .START_LOW_US  (START_US),
        .BIT_THRESH_US (40),
        .TIMEOUT_US    (200)
    ) dut_main (
        .clk (clk),
        .rst (rst),
        .bus (bm)
    );

    dht_reader #(
        .CLK_FREQ_HZ   (CLK_HZ),
        .START_LOW_US  (FAST_START_US),
        .BIT_THRESH_US (40),
        .TIMEOUT_US    (200)
    ) dut_fast (
        .clk (clk),
        .rst (rst),
        .bus (bf)
    );

    // View of whichever reader is currently under test.
    logic        m_oe, m_valid, m_busy, m_err;
    logic [1:0]  m_code;
    logic [39:0] m_data;
    assign m_oe    = sel ? bf.dht_oe   : bm.dht_oe;
    assign m_valid = sel ? bf.valid    : bm.valid;
    assign m_busy  = sel ? bf.busy     : bm.busy;
    assign m_err   = sel ? bf.err      : bm.err;
    assign m_code  = sel ? bf.err_code : bm.err_code;
    assign m_data  = sel ? bf.data_out : bm.data_out;

    int cyc = 0, valid_cnt = 0, err_cnt = 0, oe_cnt = 0, rel_cyc = 0, err_cyc = 0;
    logic oe_prev = 1'b0;

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_valid) valid_cnt = valid_cnt + 1;
        if (m_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (m_oe) oe_cnt = oe_cnt + 1;
        if (oe_prev && !m_oe) rel_cyc = cyc;
        oe_prev = m_oe;
    end

    int          hi_w [40];
    int          passed = 0;
    int          total  = 0;
    logic [39:0] exp_f  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] csum(input logic [39:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s;
    endfunction

    function automatic logic [39:0] with_sum(input logic [31:0] d);
        return {d, csum({d, 8'h00})};
    endfunction

    // Reference decode: a bit is 1 exactly when its high phase exceeds 40 us.
    function automatic logic [39:0] model_decode();
        logic [39:0] f;
        f = '0;
        for (int i = 0; i < 40; i++) f[39-i] = (hi_w[i] > 40);
        return f;
    endfunction

    task automatic widths_nominal(input logic [39:0] f);
        for (int i = 0; i < 40; i++) hi_w[i] = f[39-i] ? 70 : 26;
    endtask

    task automatic widths_random(input logic [39:0] f);
        for (int i = 0; i < 40; i++)
            hi_w[i] = f[39-i] ? int'($urandom_range(80, 41)) : int'($urandom_range(40, 18));
    endtask

    // Sensor side: wait for the host release, answer, then send nbits bits.
    // nbits < 0 models a silent sensor; stuck leaves the line high at the end.
    task automatic drive_frame(input string tag, input int nbits, input bit stuck);
        int n;
        n = 0;
        while (m_oe !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_release"}, 64'(n < 20000), 64'(1));
        if (nbits >= 0) begin
            repeat ($urandom_range(40, 20)) @(negedge clk);
            sensor_q = 1'b0;
            repeat (80) @(negedge clk);
            sensor_q = 1'b1;
            repeat (80) @(negedge clk);
            for (int i = 0; i < nbits; i++) begin
                sensor_q = 1'b0;
                repeat ($urandom_range(55, 45)) @(negedge clk);
                sensor_q = 1'b1;
                repeat (hi_w[i]) @(negedge clk);
            end
            if (!stuck) begin
                sensor_q = 1'b0;
                repeat (50) @(negedge clk);
                sensor_q = 1'b1;
            end
        end
    endtask

    task automatic run_read(input string tag, input int nbits, input bit stuck, input bit poke,
                            output int dv, output int de, output int doe);
        int v0, e0, o0, n;
        v0 = valid_cnt;
        e0 = err_cnt;
        o0 = oe_cnt;
        @(negedge clk);
        start_q = 1'b1;
        @(negedge clk);
        start_q = 1'b0;
        check({tag, "_oe_after_start"}, 64'(m_oe), 64'(1));
        check({tag, "_busy_after_start"}, 64'(m_busy), 64'(1));
        if (poke) begin
            repeat (100) @(negedge clk);
            start_q = 1'b1;
            @(negedge clk);
            start_q = 1'b0;
        end
        drive_frame(tag, nbits, stuck);
        n = 0;
        while (m_busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 64'(m_busy), 64'(0));
        repeat (2) @(negedge clk);
        dv  = valid_cnt - v0;
        de  = err_cnt - e0;
        doe = oe_cnt - o0;
    endtask

    // Expected outcome of a complete frame according to the decode/checksum rules.
    task automatic expect_frame(input string tag, input int dv, input int de);
        logic [39:0] f;
        bit          good;
        f = model_decode();
`ifdef DHT_CHECKSUM_EN
        good = (csum(f) == f[7:0]);
`else
        good = 1'b1;
`endif
        if (good) begin
            check({tag, "_data"}, 64'(m_data), 64'(f));
            check({tag, "_valid_pulses"}, 64'(dv), 64'(1));
            check({tag, "_err_pulses"}, 64'(de), 64'(0));
            exp_f = f;
        end else begin
            check({tag, "_data_kept"}, 64'(m_data), 64'(exp_f));
            check({tag, "_err_pulses"}, 64'(de), 64'(1));
            check({tag, "_err_code"}, 64'(m_code), 64'(2'b11));
        end
    endtask

    initial begin
        int          dv, de, doe, n, o0, lat;
        logic [39:0] f;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_oe", 64'(m_oe), 64'(0));
        check("rst_data", 64'(m_data), 64'(0));
        check("rst_valid", 64'(m_valid), 64'(0));
        check("rst_busy", 64'(m_busy), 64'(0));
        check("rst_err", 64'(m_err), 64'(0));
        check("rst_code", 64'(m_code), 64'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Good frame on the full-length reader, with a start poke while busy
        f = 40'h028C015FEE;
        widths_nominal(f);
        run_read("good", 40, 1'b0, 1'b1, dv, de, doe);
        check("good_data", 64'(m_data), 64'h028C015FEE);
        check("good_valid_pulses", 64'(dv), 64'(1));
        check("good_err_pulses", 64'(de), 64'(0));
        check("good_oe_cycles", 64'(doe), 64'(18000));

        // Remaining scenarios on the short-start reader
        sel = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            f = with_sum($urandom);
            widths_random(f);
            run_read("rand", 40, 1'b0, 1'b0, dv, de, doe);
            expect_frame("rand", dv, de);
        end

        f = with_sum($urandom);
        for (int i = 0; i < 40; i++) hi_w[i] = f[39-i] ? 41 : 40;
        run_read("thresh", 40, 1'b0, 1'b0, dv, de, doe);
        expect_frame("thresh", dv, de);

        f = 40'h028C015FEF;
        widths_nominal(f);
        run_read("badsum", 40, 1'b0, 1'b0, dv, de, doe);
        expect_frame("badsum", dv, de);
`ifndef DHT_CHECKSUM_EN
        check("badsum_data_lit", 64'(m_data), 64'h028C015FEF);
`endif

        run_read("silent", -1, 1'b0, 1'b0, dv, de, doe);
        lat = err_cyc - rel_cyc;
        check("silent_err_pulses", 64'(de), 64'(1));
        check("silent_err_code", 64'(m_code), 64'(2'b01));
        check("silent_latency_200_to_203", 64'(lat >= 200 && lat <= 203), 64'(1));
        check("silent_data_kept", 64'(m_data), 64'(exp_f));

        f = with_sum($urandom);
        widths_random(f);
        run_read("stuck", 17, 1'b1, 1'b0, dv, de, doe);
        check("stuck_err_pulses", 64'(de), 64'(1));
        check("stuck_valid_pulses", 64'(dv), 64'(0));
        check("stuck_err_code", 64'(m_code), 64'(2'b10));
        check("stuck_data_kept", 64'(m_data), 64'(exp_f));

        // Reset in the middle of the start pulse of the full-length reader
        sel = 1'b0;
        sensor_q = 1'b1;
        repeat (3) @(negedge clk);
        o0 = oe_cnt;
        start_q = 1'b1;
        @(negedge clk);
        start_q = 1'b0;
        n = 0;
        while ((oe_cnt - o0) < 5000 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_oe", 64'(m_oe), 64'(0));
        check("midrst_busy", 64'(m_busy), 64'(0));
        check("midrst_data", 64'(m_data), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
